// File: rtl/sc_nadder_seq_if.sv
// rtl/sc_nadder_seq_if.sv - stream/handshake bundle for the stochastic N-input scaled adder
// ones_count exists only when SC_NADDER_ACCUM_EN is defined.
interface sc_nadder_seq_if #(
    parameter int INPUT_STREAMS = 8
`ifdef SC_NADDER_ACCUM_EN
    ,
    parameter int CNT_WIDTH     = 9
`endif
);
    logic                     start;
    logic                     sel_mode;
    logic [INPUT_STREAMS-1:0] x;
    logic                     in_valid;
    logic                     out;
    logic                     out_valid;
    logic                     busy;
    logic                     done;
`ifdef SC_NADDER_ACCUM_EN
    logic [CNT_WIDTH-1:0]     ones_count;

    modport master (
        output start, sel_mode, x, in_valid,
        input  out, out_valid, busy, done, ones_count
    );

    modport slave (
        input  start, sel_mode, x, in_valid,
        output out, out_valid, busy, done, ones_count
    );
`else
    modport master (
        output start, sel_mode, x, in_valid,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, sel_mode, x, in_valid,
        output out, out_valid, busy, done
    );
`endif
endinterface

// File: rtl/sc_nadder_seq.sv
// rtl/sc_nadder_seq.sv - sequential stochastic N-input scaled adder, round-robin or LFSR select
// Optional ones accumulator enabled by defining SC_NADDER_ACCUM_EN.
module sc_nadder_seq #(
    parameter int          INPUT_STREAMS = 8,
    parameter int          SELECT_WIDTH  = 3,
    parameter int          STREAM_LEN    = 256,
    parameter int          CNT_WIDTH     = 9,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    sc_nadder_seq_if.slave      bus
);

    localparam logic [15:0]             SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [SELECT_WIDTH-1:0] IDX_N    = SELECT_WIDTH'(INPUT_STREAMS);
    localparam logic [SELECT_WIDTH-1:0] IDX_LAST = SELECT_WIDTH'(INPUT_STREAMS - 1);
    localparam logic [CNT_WIDTH-1:0]    CNT_LAST = CNT_WIDTH'(STREAM_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic                    mode;
    logic [SELECT_WIDTH-1:0] sel;
    logic [CNT_WIDTH-1:0]    bit_cnt;
    logic [15:0]             lfsr;

    logic [SELECT_WIDTH-1:0] lfsr_r;
    logic [SELECT_WIDTH-1:0] lfsr_idx;
    logic [SELECT_WIDTH-1:0] sel_idx;
    logic                    lfsr_fb;
    logic                    accept;
    logic                    last_bit;
    logic                    start_ok;
    logic                    x_bit;

    always_comb begin
        lfsr_r   = lfsr[SELECT_WIDTH-1:0];
        // Out-of-range LFSR indices fold back by N; biased for non-power-of-2 N.
        lfsr_idx = (int'(lfsr_r) >= INPUT_STREAMS) ? (lfsr_r - IDX_N) : lfsr_r;
        sel_idx  = mode ? lfsr_idx : sel;
        x_bit    = bus.x[sel_idx];
        lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        accept   = (state == S_RUN) && bus.in_valid;
        last_bit = (bit_cnt == CNT_LAST);
        start_ok = bus.start && ((state == S_IDLE) || (state == S_DONE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            mode          <= 1'b0;
            sel           <= '0;
            bit_cnt       <= '0;
            lfsr          <= SEED_EFF;
            bus.out       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
`ifdef SC_NADDER_ACCUM_EN
            bus.ones_count <= '0;
`endif
        end else begin
            bus.out_valid <= accept;
            bus.done      <= 1'b0;
            if (accept) begin
                bus.out <= x_bit;
            end

`ifdef SC_NADDER_ACCUM_EN
            // Counted on the same edge that registers out, so the total is final with done.
            if (start_ok) begin
                bus.ones_count <= '0;
            end else if (accept && x_bit) begin
                bus.ones_count <= bus.ones_count + 1'b1;
            end
`endif

            if (start_ok) begin
                state    <= S_RUN;
                bus.busy <= 1'b1;
                mode     <= bus.sel_mode;
                sel      <= '0;
                bit_cnt  <= '0;
                lfsr     <= SEED_EFF;
            end else begin
                case (state)
                    S_RUN: begin
                        if (accept) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sel     <= (sel == IDX_LAST) ? '0 : sel + 1'b1;
                            lfsr    <= {lfsr[14:0], lfsr_fb};
                            if (last_bit) begin
                                state    <= S_DONE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
